// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle fetch/exec/mem control sequencer with retired-instruction count.
// Optional single-step mode (PAUSE state) enabled by defining CTRL_SEQ_STEP_EN.
module ctrl_seq #(
    parameter int IW      = 9,
    parameter int MEM_LAT = 1,
    parameter int CW      = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Step,
    input  logic [IW-1:0] Instruction,
    output logic          BranchEn,
    output logic          RegWrEn,
    output logic          MemWrEn,
    output logic          ALUEn,
    output logic          LUTdm,
    output logic          Jump,
    output logic          SetInst,
    output logic          PcEn,
    output logic          Busy,
    output logic          Ack,
    output logic [CW-1:0] InstCount
);

`ifdef CTRL_SEQ_STEP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT, S_PAUSE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT
    } state_t;
    logic unused_step;
    assign unused_step = Step;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic [3:0]    wait_q, wait_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_clr;
    logic [3:0]    op;
    logic          is_halt, is_mem, is_alu, is_jmp, is_br;

    assign op      = ir_q[IW-1:IW-4];
    assign is_halt = &ir_q;
    assign is_mem  = op inside {4'h0, 4'h1, 4'h2, 4'h3};
    assign is_alu  = op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE};
    assign is_jmp  = op inside {4'h9, 4'hA};
    assign is_br   = op inside {4'hB, 4'hD};

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        cnt_clr  = 1'b0;
        BranchEn = 1'b0;
        RegWrEn  = 1'b0;
        MemWrEn  = 1'b0;
        ALUEn    = 1'b0;
        LUTdm    = 1'b0;
        Jump     = 1'b0;
        SetInst  = 1'b0;
        PcEn     = 1'b0;
        Busy     = 1'b0;
        Ack      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    cnt_clr = 1'b1;
                end
            end
            S_FETCH: begin
                Busy    = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                Busy = 1'b1;
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_mem) begin
                    state_d = S_MEM;
                    wait_d  = 4'(MEM_LAT - 1);
                end else begin
                    PcEn    = 1'b1;
                    state_d = S_FETCH;
                    unique case (1'b1)
                        is_alu: begin
                            ALUEn   = 1'b1;
                            RegWrEn = 1'b1;
                        end
                        is_jmp: begin
                            ALUEn   = 1'b1;
                            RegWrEn = 1'b1;
                            Jump    = 1'b1;
                            SetInst = 1'b1;
                        end
                        is_br:   BranchEn = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                Busy = 1'b1;
                if (wait_q == 4'd0) begin
                    PcEn    = 1'b1;
                    RegWrEn = ~op[1];
                    MemWrEn = op[1];
                    // 0001 and 0010 go through the LUT data path
                    LUTdm   = op[1] ^ op[0];
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_HALT: begin
                Ack = 1'b1;
                if (Start) begin
                    state_d = S_FETCH;
                    cnt_clr = 1'b1;
                end
            end
`ifdef CTRL_SEQ_STEP_EN
            S_PAUSE: begin
                Busy = 1'b1;
                if (Step) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef CTRL_SEQ_STEP_EN
        if (PcEn) state_d = S_PAUSE;
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_FETCH) ir_q <= Instruction;
            if (cnt_clr)
                cnt_q <= '0;
            else if (PcEn && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign InstCount = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed and random checks of ctrl_seq against a cycle-queue model.
// Default build only (CTRL_SEQ_STEP_EN undefined).
module tb_ctrl_seq;
    localparam int IW = 9;
    localparam int ML = 3;
    localparam int CW = 4;

    localparam logic [IW-1:0] ADD  = 9'b0101_00011;
    localparam logic [IW-1:0] SEQ  = 9'b1010_00000;
    localparam logic [IW-1:0] SW   = 9'b0010_00001;
    localparam logic [IW-1:0] LW   = 9'b0000_00010;
    localparam logic [IW-1:0] HLT  = 9'h1FF;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic          Step = 1'b0;
    logic [IW-1:0] Instruction = '0;
    logic          BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm;
    logic          Jump, SetInst, PcEn, Busy, Ack;
    logic [CW-1:0] InstCount;

    always #5 Clk = ~Clk;

    ctrl_seq #(.IW(IW), .MEM_LAT(ML), .CW(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Step(Step),
        .Instruction(Instruction),
        .BranchEn(BranchEn), .RegWrEn(RegWrEn), .MemWrEn(MemWrEn),
        .ALUEn(ALUEn), .LUTdm(LUTdm), .Jump(Jump), .SetInst(SetInst),
        .PcEn(PcEn), .Busy(Busy), .Ack(Ack), .InstCount(InstCount)
    );

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

    int          total = 0;
    int          bad = 0;
    mode_t       mode = M_IDLE;
    int          cnt = 0;
    logic [10:0] q[$];
    logic [9:0]  got;
    logic [9:0]  h[5];

    // {Branch,RegWr,MemWr,ALU,LUTdm,Jump,SetInst,PcEn,Busy,Ack}
    function automatic logic [9:0] outs();
        return {BranchEn, RegWrEn, MemWrEn, ALUEn, LUTdm,
                Jump, SetInst, PcEn, Busy, Ack};
    endfunction

    task automatic check(input string nm, input logic [31:0] g,
                         input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, g, e, $time);
        end
    endtask

    // Expand one instruction into its cycle-by-cycle expected outputs.
    task automatic expand(input logic [IW-1:0] ins);
        logic [3:0] op;
        logic [9:0] w;
        op = ins[IW-1:IW-4];
        q.push_back(11'h002);
        if (&ins) begin
            q.push_back(11'h402);
        end else if (op < 4'd4) begin
            q.push_back(11'h002);
            for (int i = 1; i < ML; i++) q.push_back(11'h002);
            w = 10'h006 | ((op < 4'd2) ? 10'h100 : 10'h080);
            if (op == 4'd1 || op == 4'd2) w = w | 10'h020;
            q.push_back({1'b0, w});
        end else begin
            w = 10'h006;
            case (op)
                4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE: w = w | 10'h140;
                4'h9, 4'hA:                         w = w | 10'h158;
                4'hB, 4'hD:                         w = w | 10'h200;
                default:                            ;
            endcase
            q.push_back({1'b0, w});
        end
    endtask

    task automatic cyc(input logic st, input logic [IW-1:0] ins);
        logic [10:0] e;
        @(negedge Clk);
        Start = st;
        Instruction = ins;
        if (mode == M_RUN && q.size() == 0) expand(ins);
        if (mode == M_RUN)       e = q[0];
        else if (mode == M_HALT) e = 11'h001;
        else                     e = 11'h000;
        got = outs();
        check("outs", 32'(got), 32'(e[9:0]));
        check("count", 32'(InstCount), 32'(cnt));
        if (mode == M_RUN) begin
            e = q.pop_front();
            if (e[2] && cnt < 2**CW - 1) cnt++;
            if (e[10]) mode = M_HALT;
        end else if (st) begin
            mode = M_RUN;
            cnt = 0;
        end
    endtask

    initial begin
        #1;
        check("rst_outs", 32'(outs()), 32'h0);
        check("rst_count", 32'(InstCount), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(0, ADD);
        cyc(0, ADD);

        cyc(1, '0);
        cyc(0, ADD);
        cyc(0, ADD);
        check("add_exec", 32'(got), 32'h146);
        cyc(0, HLT);
        check("add_count", 32'(InstCount), 32'd1);
        cyc(0, '0);

        cyc(1, '0);
        check("halt_ack", 32'(got), 32'h001);
        cyc(0, ADD);
        check("restart_ack", 32'(got), 32'h002);
        check("restart_cnt", 32'(InstCount), 32'd0);
        cyc(0, '0);
        cyc(0, SEQ);
        cyc(0, '0);
        check("seq_exec", 32'(got), 32'h15E);
        cyc(0, HLT);
        cyc(0, '0);
        cyc(0, '0);
        check("seq_halt", 32'(got), 32'h001);
        check("seq_count", 32'(InstCount), 32'd2);

        cyc(1, '0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, SW);
            h[i] = got;
        end
        check("sw_wait", 32'(h[3]), 32'h002);
        check("sw_done", 32'(h[4]), 32'h0A6);

        cyc(0, LW);
        cyc(0, '0);
        cyc(0, '0);
        Reset_n = 1'b0;
        #1;
        check("midmem_outs", 32'(outs()), 32'h0);
        check("midmem_cnt", 32'(InstCount), 32'h0);
        mode = M_IDLE;
        q.delete();
        cnt = 0;
        @(negedge Clk);
        check("rst_hold", 32'(outs()), 32'h0);
        Reset_n = 1'b1;
        cyc(0, '0);
        cyc(0, '0);

        cyc(1, '0);
        for (int i = 0; i < 40; i++) cyc(0, ADD);
        for (int i = 0; i < 8 && mode != M_HALT; i++) cyc(0, HLT);
        cyc(0, '0);
        check("sat_count", 32'(InstCount), 32'd15);

        for (int i = 0; i < 3000; i++) begin
            logic [IW-1:0] r;
            r = ($urandom % 20 == 0) ? HLT : IW'($urandom);
            cyc(($urandom % 4) == 0, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
